apb_req_arbiter: RTL
====================

APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

Interface
REQ-001 Parameter NSLV, default 8, number of decoded APB slaves (1..8).
REQ-002 Parameter TIMEOUT, default 16, maximum ACCESS cycles before abort (2..255).
REQ-003 PCLK  in  1  single clock; all state updates on rising edge.
REQ-004 PRST  in  1  reset, synchronous, active-high.
REQ-005 REQ  in  2  transfer request, bit i = requester i; held high until DONE[i].
REQ-006 RWRITE  in  2  direction per requester: 1 = write, 0 = read.
REQ-007 RADDR  in  64  requester i address at [32i+31:32i].
REQ-008 RWDATA  in  64  requester i write data at [32i+31:32i].
REQ-009 RSTRB  in  8  requester i byte strobes at [4i+3:4i].
REQ-010 DONE  out  2  one-cycle completion pulse to the granted requester.
REQ-011 RDATA  out  32  read data, valid only while DONE is nonzero.
REQ-012 RERR  out  1  error flag, valid only while DONE is nonzero.
REQ-013 PSEL  out  8  one-hot slave select.
REQ-014 PENABLE  out  1  APB access phase.
REQ-015 PWRITE / PSTRB / PADDR / PWDATA  out  1/4/32/32  APB command fields.
REQ-016 PREADY / PSLVERR / PRDATA  in  1/1/32  APB slave response.

Function
REQ-017 Slave index = PADDR[14:12]; index >= NSLV is a decode error.
REQ-018 States: IDLE, SETUP, ACCESS, RESP; reset state IDLE.
REQ-019 IDLE with any REQ high: grant one requester, latch its RWRITE/RADDR/RWDATA/RSTRB, go to SETUP next edge.
REQ-020 Arbitration is round-robin: on simultaneous requests, grant the requester not served last; after reset, requester 0 wins a tie.
REQ-021 SETUP: PSEL one-hot at the decoded index, PENABLE=0, command fields from the latched copy; go to ACCESS after exactly one cycle.
REQ-022 ACCESS: PENABLE=1, PSEL and command fields unchanged; stay until PREADY=1 or the timeout fires.
REQ-023 PREADY=1 in ACCESS: capture PRDATA (reads only, else 0) and PSLVERR; PSEL and PENABLE go 0 next edge; go to RESP.
REQ-024 RESP: DONE[grant]=1 for exactly one cycle, RDATA/RERR driven; then IDLE.
REQ-025 Best-case latency: REQ sampled in IDLE at edge 0, SETUP cycle 1, ACCESS cycle 2, DONE cycle 3; at least one IDLE cycle between transfers.
REQ-026 On reads PSTRB=0 and PWDATA=0; on writes PSTRB equals the latched RSTRB.
REQ-027 Decode error: no PSEL asserted, no APB cycle; go IDLE to RESP directly, DONE with RERR=1 and RDATA=0 (latency 1).
REQ-028 Timeout: an 8-bit counter clears on SETUP exit and increments each ACCESS cycle; if TIMEOUT ACCESS cycles pass without PREADY, drop PSEL/PENABLE, go to RESP with RERR=1 and RDATA=0.
REQ-029 Requester inputs that change after grant do not affect the transfer in flight.
REQ-030 A REQ deasserted before its DONE is a protocol violation; behaviour is undefined and the bench does not drive it.

Reset
REQ-031 While PRST=1: state IDLE, all outputs 0, round-robin pointer favours requester 0, timeout counter 0.
REQ-032 Reset mid-transfer abandons it: PSEL and PENABLE are 0 from the next edge, and no DONE is issued for the abandoned request.

Structure
REQ-033 Package apb_arb_pkg holds the state enum, the slave-index bit positions (14:12), the default NSLV/TIMEOUT and the width constants.
REQ-034 Sub-module rr_arb2 is the 2-way round-robin grant: inputs req[1:0] and an update strobe; output one-hot grant[1:0].

Verification
REQ-035 Single write: R0 RADDR=0x0000_1004, RWDATA=0xA5, RSTRB=0xF, PREADY tied 1 -> PSEL=0x02 in SETUP, PENABLE in cycle 2, DONE=01 in cycle 3, RERR=0.
REQ-036 Read with wait states: R1 RADDR=0x0000_2000, PREADY low for 3 ACCESS cycles, PRDATA=0x1234 -> PSEL=0x04 stable, DONE=10, RDATA=0x1234, PSTRB=0.
REQ-037 Contention: REQ=11 held continuously for 4 transfers -> grants 0,1,0,1, each separated by at least one IDLE cycle.
REQ-038 Decode error: NSLV=4, RADDR=0x0000_5000 -> PSEL stays 0, DONE one cycle after the request, RERR=1, RDATA=0.
REQ-039 Timeout and PSLVERR: PREADY held 0 -> DONE after 16 ACCESS cycles with RERR=1; separately PREADY=1 with PSLVERR=1 -> RERR=1.
REQ-040 Reset in ACCESS: PRST pulsed during cycle 2 -> PSEL/PENABLE 0 next edge, no DONE, next REQ=11 grants requester 0.

Source files
------------

// File: rtl/apb_arb_pkg.sv
// Shared constants, state encoding and helpers for the two-requester APB arbiter.
package apb_arb_pkg;

   localparam int NREQ        = 2;
   localparam int ADDR_W      = 32;
   localparam int DATA_W      = 32;
   localparam int STRB_W      = 4;
   localparam int SLV_MAX     = 8;
   localparam int CNT_W       = 8;
   localparam int SLV_IDX_HI  = 14;
   localparam int SLV_IDX_LO  = 12;
   localparam int SLV_IDX_W   = SLV_IDX_HI - SLV_IDX_LO + 1;
   localparam int DEF_NSLV    = 8;
   localparam int DEF_TIMEOUT = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } state_e;

   // One-hot slave select for a decoded slave index.
   function automatic logic [SLV_MAX-1:0] slv_onehot(input logic [SLV_IDX_W-1:0] idx);
      slv_onehot      = '0;
      slv_onehot[idx] = 1'b1;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant. On a tie the requester that was not served last wins;
// after reset requester 0 wins the first tie.
module rr_arb2
   import apb_arb_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] req,
   input  logic            update,
   output logic [NREQ-1:0] grant
);

   // r_last = 1 means requester 1 was served most recently.
   logic r_last;

   // Combinational one-hot grant from the current requests and the pointer.
   always_comb begin
      grant = 2'b00;
      if (req == 2'b11) begin
         grant = r_last ? 2'b01 : 2'b10;
      end else begin
         grant = req;
      end
   end

   // Remember who was served when the owner commits a grant.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_last <= 1'b1;
      end else if (update && (|grant)) begin
         r_last <= grant[1];
      end
   end

endmodule

// File: rtl/apb_req_arbiter.sv
// Arbitrates two request ports onto one APB master. A granted request is latched,
// decoded to a slave by address bits 14:12 and run as a SETUP/ACCESS cycle; the
// result returns as a one-cycle DONE pulse. Decode errors skip the APB cycle and
// stalled slaves are abandoned after TIMEOUT access cycles.
//
// Handshake: REQ[i] rises with its command fields valid and stays high until the
// cycle where DONE[i] is 1; RDATA/RERR are meaningful only in that cycle. On the
// APB side the slave completes an access by driving PREADY=1 while PENABLE=1.
module apb_req_arbiter
   import apb_arb_pkg::*;
#(
   parameter int NSLV    = DEF_NSLV,
   parameter int TIMEOUT = DEF_TIMEOUT
)
(
   input  logic                   PCLK,
   input  logic                   PRST,
   input  logic [NREQ-1:0]        REQ,
   input  logic [NREQ-1:0]        RWRITE,
   input  logic [NREQ*ADDR_W-1:0] RADDR,
   input  logic [NREQ*DATA_W-1:0] RWDATA,
   input  logic [NREQ*STRB_W-1:0] RSTRB,
   output logic [NREQ-1:0]        DONE,
   output logic [DATA_W-1:0]      RDATA,
   output logic                   RERR,
   output logic [SLV_MAX-1:0]     PSEL,
   output logic                   PENABLE,
   output logic                   PWRITE,
   output logic [STRB_W-1:0]      PSTRB,
   output logic [ADDR_W-1:0]      PADDR,
   output logic [DATA_W-1:0]      PWDATA,
   input  logic                   PREADY,
   input  logic                   PSLVERR,
   input  logic [DATA_W-1:0]      PRDATA,
   output logic [1:0]             DBG_STATE
);

   state_e                r_state;
   logic [NREQ-1:0]       r_grant;
   logic                  r_write;
   logic [ADDR_W-1:0]     r_addr;
   logic [DATA_W-1:0]     r_wdata;
   logic [STRB_W-1:0]     r_strb;
   logic [SLV_MAX-1:0]    r_sel;
   logic [CNT_W-1:0]      r_cnt;
   logic [DATA_W-1:0]     r_rdata;
   logic                  r_err;

   logic [NREQ-1:0]       w_grant;
   logic                  w_update;
   logic                  w_gsel;
   logic                  w_rwrite;
   logic [ADDR_W-1:0]     w_raddr;
   logic [DATA_W-1:0]     w_rwdata;
   logic [STRB_W-1:0]     w_rstrb;
   logic [SLV_IDX_W-1:0]  w_idx;
   logic                  w_dec_err;
   logic                  w_apb_act;
   logic                  w_timeout;

   // Commit a grant only when idle with a pending request.
   assign w_update = (r_state == ST_IDLE) && (|REQ);

   rr_arb2 u_rr_arb2 (
      .clk    (PCLK),
      .rst    (PRST),
      .req    (REQ),
      .update (w_update),
      .grant  (w_grant)
   );

   // Select the granted requester's command fields.
   assign w_gsel    = w_grant[1];
   assign w_rwrite  = w_gsel ? RWRITE[1]     : RWRITE[0];
   assign w_raddr   = w_gsel ? RADDR[63:32]  : RADDR[31:0];
   assign w_rwdata  = w_gsel ? RWDATA[63:32] : RWDATA[31:0];
   assign w_rstrb   = w_gsel ? RSTRB[7:4]    : RSTRB[3:0];
   assign w_idx     = w_raddr[SLV_IDX_HI:SLV_IDX_LO];
   assign w_dec_err = (int'(w_idx) >= NSLV);
   assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

   // Transfer sequencing: latch on grant, run SETUP/ACCESS, report in RESP.
   always_ff @(posedge PCLK) begin
      if (PRST) begin
         r_state <= ST_IDLE;
         r_grant <= '0;
         r_write <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_strb  <= '0;
         r_sel   <= '0;
         r_cnt   <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (|REQ) begin
                  r_grant <= w_grant;
                  r_write <= w_rwrite;
                  r_addr  <= w_raddr;
                  // Reads never show write data or strobes on the bus.
                  r_wdata <= w_rwrite ? w_rwdata : '0;
                  r_strb  <= w_rwrite ? w_rstrb  : '0;
                  r_sel   <= w_dec_err ? '0 : slv_onehot(w_idx);
                  r_cnt   <= '0;
                  if (w_dec_err) begin
                     r_rdata <= '0;
                     r_err   <= 1'b1;
                     r_state <= ST_RESP;
                  end else begin
                     r_state <= ST_SETUP;
                  end
               end
            end
            ST_SETUP: begin
               r_cnt   <= '0;
               r_state <= ST_ACCESS;
            end
            ST_ACCESS: begin
               if (PREADY) begin
                  r_rdata <= r_write ? '0 : PRDATA;
                  r_err   <= PSLVERR;
                  r_state <= ST_RESP;
               end else if (w_timeout) begin
                  r_rdata <= '0;
                  r_err   <= 1'b1;
                  r_state <= ST_RESP;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_RESP: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // APB and completion outputs are decoded from the state and the latched copy.
   assign w_apb_act = (r_state == ST_SETUP) || (r_state == ST_ACCESS);
   assign PSEL      = w_apb_act ? r_sel : '0;
   assign PENABLE   = (r_state == ST_ACCESS);
   assign PWRITE    = r_write;
   assign PADDR     = r_addr;
   assign PWDATA    = r_wdata;
   assign PSTRB     = r_strb;
   assign DONE      = (r_state == ST_RESP) ? r_grant : '0;
   assign RDATA     = (r_state == ST_RESP) ? r_rdata : '0;
   assign RERR      = (r_state == ST_RESP) && r_err;
   assign DBG_STATE = r_state;

endmodule
